load_counter_param: RTL and testbench
=====================================

// Module: load_counter_param
// PURPOSE
// - Parametrised up/down counter with a handshaked two-phase load, wrap or saturate mode and terminal-count pulse.
// - Generalises the 8-bit loadable counter: the two-cycle-hold load becomes a valid/ready handshake.
// - out_ena still drops for exactly one cycle around each load. Sits between host config logic and downstream enable consumers.
// PARAMETERS
// - WIDTH       8    counter/load/compare width in bits (2..32)
// - MAX_VALUE   2**WIDTH-1  terminal value; count range is 0..MAX_VALUE
// - RESET_VALUE 0    counter value after reset (must be <= MAX_VALUE)
// - SATURATE    0    0 = wrap at boundaries, 1 = hold at boundaries
// - ENA_W       8    width of out_ena
// PORTS
// - in_clk            in   1      clock, all logic on rising edge
// - in_rst            in   1      synchronous reset, active-high
// - in_load_valid     in   1      load request
// - in_load_value     in   WIDTH  value to load, sampled on accept
// - out_load_ready    out  1      high when a load can be accepted
// - in_count_en       in   1      step enable
// - in_dir            in   1      0 = count up, 1 = count down
// - out_counter_value out  WIDTH  current count
// - out_ena           out  ENA_W  all-ones while running, all-zeros during load hold
// - out_tc            out  1      terminal-count pulse
// - in_cmp_value      in   WIDTH  compare value (COUNTER_CMP_EN only)
// - out_cmp_match     out  1      compare match (COUNTER_CMP_EN only)
// BEHAVIOUR
// - Reset (in_rst=1 at edge): value=RESET_VALUE, out_ena=all-ones, out_load_ready=1, out_tc=0, state=RUN, capture reg=0.
// - Reset mid-load (state HOLD): pending load discarded, reset values apply.
// - FSM RUN: ready=1. Accept = in_load_valid & out_load_ready at an edge -> capture min(in_load_value, MAX_VALUE),
//   out_ena<=0, state<=HOLD. Value does not step on the accept edge (load beats count_en).
// - FSM HOLD (exactly one cycle): ready=0, in_load_valid and in_count_en ignored, value frozen.
//   Next edge: value<=captured, out_ena<=all-ones, state<=RUN.
// - Load latency: new value visible 2 edges after accept; out_ena low for exactly 1 cycle. Back-to-back loads: one per 2 cycles.
// - Step in RUN with in_count_en=1 and no accept: up -> value+1, down -> value-1.
// - Up at MAX_VALUE: wrap to 0 (SATURATE=0) or hold MAX_VALUE (SATURATE=1). Down at 0: wrap to MAX_VALUE or hold 0.
// - out_tc registered: high for the one cycle after an enabled step taken from the terminal value
//   (MAX_VALUE up, 0 down). In saturate mode it re-asserts every enabled cycle spent at the terminal. Never set in HOLD or on the load edge.
// - Arithmetic at WIDTH bits; MAX_VALUE < 2**WIDTH-1 wraps explicitly at MAX_VALUE, never at natural overflow.
// - in_dir change takes effect on the very next step; no pipelining.
// CONFIGURATION
// - COUNTER_CMP_EN defined: ports in_cmp_value/out_cmp_match present; out_cmp_match registered,
//   high for the cycle after out_counter_value == in_cmp_value; reset 0; held low in HOLD.
// - COUNTER_CMP_EN undefined: both ports and compare logic absent; all other behaviour identical.
// STRUCTURE
// - counter_pkg: state enum {ST_RUN, ST_HOLD}, DIR_UP=1'b0 / DIR_DOWN=1'b1 constants, ENA_ON/ENA_OFF helpers.
// - Sub-module counter_load_ctrl: RUN/HOLD FSM, capture register, clamp, out_load_ready and out_ena generation;
//   top holds the count/step/wrap datapath, out_tc and optional compare.
// TESTING (WIDTH=8, MAX_VALUE=255, ENA_W=8 unless noted)
// - Reset: hold in_rst 2 cycles with count_en=1 -> value=0, out_ena=8'hFF, ready=1, tc=0; release -> counts 1,2,3.
// - Load: at value 5 assert valid with 8'hA0 one cycle -> out_ena=0x00 one cycle, ready low one cycle, value 0xA0 two edges after accept, then 0xA1.
// - Wrap: MAX_VALUE=9, SATURATE=0, up from 8 -> 9,0,1 with tc high only the cycle value=0; down from 1 -> 0,9 with tc on 9.
// - Saturate: SATURATE=1 up from 254 -> 255,255,255, tc high each cycle after the first enabled step at 255.
// - Clamp and collision: MAX_VALUE=100, load 200 while count_en=1 -> value 100, no step on accept edge; valid held through HOLD not double-accepted.
// - Reset mid-load + compare (COUNTER_CMP_EN): reset in HOLD -> value=RESET_VALUE, ena=FF; in_cmp_value=3 -> match high exactly the cycle after value=3.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and constants for the loadable up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Enable patterns sized for the widest supported out_ena; users slice them.
    localparam int          ENA_MAX_W = 64;
    localparam logic [63:0] ENA_ON    = '1;
    localparam logic [63:0] ENA_OFF   = '0;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_load_ctrl.sv
// ============================================================================
// Module      : counter_load_ctrl
// Description : RUN/HOLD load handshake FSM with clamped capture register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_load_ctrl
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
    parameter int          ENA_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_load_ready,
    output logic [ENA_W-1:0] o_ena,
    output logic             o_accept,
    output logic             o_hold,
    output logic [WIDTH-1:0] o_cap_value
);

    localparam logic [WIDTH-1:0] c_MAX      = WIDTH'(MAX_VALUE);
    localparam logic [ENA_W-1:0] c_ENA_ON   = ENA_ON[ENA_W-1:0];
    localparam logic [ENA_W-1:0] c_ENA_OFF  = ENA_OFF[ENA_W-1:0];

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic [WIDTH-1:0] r_cap;

    assign w_accept    = i_load_valid && (r_state == ST_RUN);
    assign o_accept    = w_accept;
    assign o_cap_value = r_cap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HOLD always lasts exactly one cycle; requests during it are ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_accept) w_state_next = ST_HOLD;
            ST_HOLD: w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        o_load_ready = 1'b1;
        o_ena        = c_ENA_ON;
        o_hold       = 1'b0;
        if (r_state == ST_HOLD) begin
            o_load_ready = 1'b0;
            o_ena        = c_ENA_OFF;
            o_hold       = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap <= '0;
        end else if (w_accept) begin
            r_cap <= (i_load_value > c_MAX) ? c_MAX : i_load_value;
        end
    end

endmodule : counter_load_ctrl

`default_nettype wire

// File: rtl/load_counter_param.sv
// ============================================================================
// Module      : load_counter_param
// Description : Parametrised up/down counter with handshaked load, wrap or
//               saturate mode, terminal-count pulse. Optional compare output
//               enabled by defining COUNTER_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_counter_param
    import counter_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int unsigned MAX_VALUE   = (2**WIDTH) - 1,
    parameter int unsigned RESET_VALUE = 0,
    parameter int          SATURATE    = 0,
    parameter int          ENA_W       = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_load_valid,
    input  logic [WIDTH-1:0] in_load_value,
    output logic             out_load_ready,
    input  logic             in_count_en,
    input  logic             in_dir,
    output logic [WIDTH-1:0] out_counter_value,
    output logic [ENA_W-1:0] out_ena,
    output logic             out_tc
`ifdef COUNTER_CMP_EN
    ,
    input  logic [WIDTH-1:0] in_cmp_value,
    output logic             out_cmp_match
`endif
);

    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
    localparam logic             c_SAT   = (SATURATE != 0);

    logic             w_accept;
    logic             w_hold;
    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;
    logic             w_at_term;
    logic             r_tc;

    counter_load_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE),
        .ENA_W     (ENA_W)
    ) u_load_ctrl (
        .i_clk        (in_clk),
        .i_rst        (in_rst),
        .i_load_valid (in_load_valid),
        .i_load_value (in_load_value),
        .o_load_ready (out_load_ready),
        .o_ena        (out_ena),
        .o_accept     (w_accept),
        .o_hold       (w_hold),
        .o_cap_value  (w_cap)
    );

    // Boundaries are explicit compares against MAX_VALUE, not carry-out.
    always_comb begin
        w_next    = r_value;
        w_at_term = 1'b0;
        if (in_dir == DIR_DOWN) begin
            w_at_term = (r_value == '0);
            w_next    = w_at_term ? (c_SAT ? '0 : c_MAX) : (r_value - c_ONE);
        end else begin
            w_at_term = (r_value == c_MAX);
            w_next    = w_at_term ? (c_SAT ? c_MAX : '0) : (r_value + c_ONE);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_value <= c_RESET;
            r_tc    <= 1'b0;
        end else if (w_hold) begin
            r_value <= w_cap;
            r_tc    <= 1'b0;
        end else if (w_accept) begin
            r_tc    <= 1'b0;
        end else if (in_count_en) begin
            r_value <= w_next;
            r_tc    <= w_at_term;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign out_counter_value = r_value;
    assign out_tc            = r_tc;

`ifdef COUNTER_CMP_EN
    logic r_cmp_match;

    // Suppressed on the accept edge too, so the match stays low through HOLD.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_cmp_match <= 1'b0;
        end else if (w_hold || w_accept) begin
            r_cmp_match <= 1'b0;
        end else begin
            r_cmp_match <= (r_value == in_cmp_value);
        end
    end

    assign out_cmp_match = r_cmp_match;
`endif

endmodule : load_counter_param

`default_nettype wire

// File: tb/tb_load_counter_param.sv
// ============================================================================
// Module      : tb_load_counter_param
// Description : Four counter configurations under shared random stimulus,
//               each compared against a behavioural model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_counter_param;

    localparam int          N_CFG = 4;
    localparam int unsigned c_MAXV [N_CFG] = '{255, 9, 255, 100};
    localparam int unsigned c_RSTV [N_CFG] = '{0, 0, 0, 5};
    localparam int          c_SATV [N_CFG] = '{0, 0, 1, 1};

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_value;
    logic       count_en;
    logic       dir;
    logic [7:0] cmp_value;

    logic       dut_ready [N_CFG];
    logic [7:0] dut_val   [N_CFG];
    logic [7:0] dut_ena   [N_CFG];
    logic       dut_tc    [N_CFG];
    logic       dut_match [N_CFG];

    int  n_checks;
    int  n_errors;

    int  m_val   [N_CFG];
    int  m_cap   [N_CFG];
    bit  m_hold  [N_CFG];
    bit  m_tc    [N_CFG];
    bit  m_match [N_CFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_CFG; g++) begin : g_dut
        load_counter_param #(
            .WIDTH       (8),
            .MAX_VALUE   (c_MAXV[g]),
            .RESET_VALUE (c_RSTV[g]),
            .SATURATE    (c_SATV[g]),
            .ENA_W       (8)
        ) u_dut (
            .in_clk            (clk),
            .in_rst            (rst),
            .in_load_valid     (load_valid),
            .in_load_value     (load_value),
            .out_load_ready    (dut_ready[g]),
            .in_count_en       (count_en),
            .in_dir            (dir),
            .out_counter_value (dut_val[g]),
            .out_ena           (dut_ena[g]),
            .out_tc            (dut_tc[g])
`ifdef COUNTER_CMP_EN
            ,
            .in_cmp_value      (cmp_value),
            .out_cmp_match     (dut_match[g])
`endif
        );
`ifndef COUNTER_CMP_EN
        assign dut_match[g] = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour applied at each rising edge with the inputs just driven.
    task automatic model_edge();
        for (int c = 0; c < N_CFG; c++) begin
            int mx;
            int v;
            mx = int'(c_MAXV[c]);
            v  = m_val[c];
            if (rst) begin
                m_val[c] = int'(c_RSTV[c]); m_cap[c] = 0; m_hold[c] = 0;
                m_tc[c] = 0; m_match[c] = 0;
            end else if (m_hold[c]) begin
                m_val[c] = m_cap[c]; m_hold[c] = 0; m_tc[c] = 0; m_match[c] = 0;
            end else if (load_valid) begin
                m_cap[c]  = (int'(load_value) > mx) ? mx : int'(load_value);
                m_hold[c] = 1; m_tc[c] = 0; m_match[c] = 0;
            end else begin
                m_match[c] = (v == int'(cmp_value));
                if (count_en) begin
                    if (dir) begin
                        m_tc[c]  = (v == 0);
                        m_val[c] = (c_SATV[c] != 0) ? ((v == 0) ? 0 : v - 1) : (v + mx) % (mx + 1);
                    end else begin
                        m_tc[c]  = (v == mx);
                        m_val[c] = (c_SATV[c] != 0) ? ((v == mx) ? mx : v + 1) : (v + 1) % (mx + 1);
                    end
                end else begin
                    m_tc[c] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < N_CFG; c++) begin
            check($sformatf("value[%0d]", c), 32'(dut_val[c]), 32'(m_val[c]));
            check($sformatf("ena[%0d]", c), 32'(dut_ena[c]), m_hold[c] ? 32'h00 : 32'hFF);
            check($sformatf("ready[%0d]", c), 32'(dut_ready[c]), 32'(!m_hold[c]));
            check($sformatf("tc[%0d]", c), 32'(dut_tc[c]), 32'(m_tc[c]));
`ifdef COUNTER_CMP_EN
            check($sformatf("match[%0d]", c), 32'(dut_match[c]), 32'(m_match[c]));
`endif
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] lv,
                         input logic en, input logic d, input logic [7:0] cv);
        rst = r; load_valid = v; load_value = lv; count_en = en; dir = d; cmp_value = cv;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] pick_load();
        logic [7:0] table_v [10];
        table_v = '{8'd0, 8'd1, 8'd8, 8'd9, 8'd99, 8'd100, 8'd200, 8'd254, 8'd255, 8'd3};
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
        return table_v[$urandom_range(0, 9)];
    endfunction

    initial begin
        int dir_left;
        logic cur_dir;
        n_checks = 0;
        n_errors = 0;
        for (int c = 0; c < N_CFG; c++) begin
            m_val[c] = 0; m_cap[c] = 0; m_hold[c] = 0; m_tc[c] = 0; m_match[c] = 0;
        end
        rst = 1'b1; load_valid = 1'b0; load_value = '0; count_en = 1'b1; dir = 1'b0; cmp_value = 8'd3;

        // Reset with counting requested, then count up, then a load at value 5.
        cycle(1, 0, 8'h00, 1, 0, 8'd3);
        cycle(1, 0, 8'h00, 1, 0, 8'd3);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1, 0, 8'd3);
        cycle(0, 1, 8'hA0, 1, 0, 8'd3);
        cycle(0, 1, 8'hA0, 1, 0, 8'd3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 0, 8'd3);
        // Load 200 with count enabled (clamps in the MAX_VALUE=100 instance).
        cycle(0, 1, 8'd200, 1, 1, 8'd3);
        cycle(0, 0, 8'd0, 1, 1, 8'd3);
        cycle(0, 0, 8'd0, 1, 1, 8'd3);
        // Reset arriving during HOLD discards the pending load.
        cycle(0, 1, 8'd7, 1, 0, 8'd3);
        cycle(1, 0, 8'd0, 1, 0, 8'd3);
        for (int i = 0; i < 6; i++) cycle(0, 0, 8'd0, 1, 0, 8'd3);

        dir_left = 0;
        cur_dir  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (dir_left == 0) begin
                cur_dir  = 1'($urandom_range(0, 1));
                dir_left = $urandom_range(1, 60);
            end
            dir_left--;
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 11) == 0),
                  pick_load(),
                  ($urandom_range(0, 3) != 0),
                  cur_dir,
                  8'($urandom_range(0, 10)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_load_counter_param

`default_nettype wire
